// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 9-bit instruction memory.
// Packs byte pairs into instructions and writes them from address 0, then checks an XOR checksum.
module imem_loader #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned INSTR_W = 9
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [7:0]        i_in_data,
   output logic              o_in_ready,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [INSTR_W-1:0] o_wr_data,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   output logic [ADDR_W:0]   o_count
);

   typedef enum logic [2:0] {
      StIdle, StLenHi, StLenLo, StInsHi, StInsLo, StChk, StDone, StErr
   } t_state;

   localparam logic [13:0] MaxLen = 14'(1 << ADDR_W);

   t_state              r_state;
   logic [7:0]          r_len_hi;
   logic [12:0]         r_remain;
   logic [7:0]          r_xor;
   logic                r_ins_hi;
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [INSTR_W-1:0]  r_wr_data;
   logic [ADDR_W:0]     r_count;
   logic                r_done;
   logic                r_error;

   logic                w_active;
   logic                w_xfer;
   logic [12:0]         w_len;

   assign w_active = (r_state == StLenHi) || (r_state == StLenLo) || (r_state == StInsHi) ||
                     (r_state == StInsLo) || (r_state == StChk);
   assign w_xfer   = w_active && i_in_valid;
   assign w_len    = {r_len_hi[4:0], i_in_data};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= StIdle;
         r_len_hi  <= '0;
         r_remain  <= '0;
         r_xor     <= '0;
         r_ins_hi  <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_count   <= '0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         unique case (r_state)
            StIdle, StDone, StErr: begin
               if (i_start) begin
                  r_state   <= StLenHi;
                  r_done    <= 1'b0;
                  r_error   <= 1'b0;
                  r_count   <= '0;
                  r_xor     <= '0;
                  r_wr_addr <= '0;
               end
            end
            StLenHi: begin
               if (w_xfer) begin
                  r_len_hi <= i_in_data;
                  r_xor    <= r_xor ^ i_in_data;
                  r_state  <= StLenLo;
               end
            end
            StLenLo: begin
               if (w_xfer) begin
                  r_xor    <= r_xor ^ i_in_data;
                  r_remain <= w_len;
                  if ((r_len_hi[7:5] != 3'b000) || ({1'b0, w_len} > MaxLen)) begin
                     r_state <= StErr;
                     r_error <= 1'b1;
                  end else if (w_len == 13'd0) begin
                     r_state <= StChk;
                  end else begin
                     r_state <= StInsHi;
                  end
               end
            end
            StInsHi: begin
               if (w_xfer) begin
                  r_xor    <= r_xor ^ i_in_data;
                  r_ins_hi <= i_in_data[0];
                  if (i_in_data[7:1] != 7'd0) begin
                     r_state <= StErr;
                     r_error <= 1'b1;
                  end else begin
                     r_state <= StInsLo;
                  end
               end
            end
            StInsLo: begin
               if (w_xfer) begin
                  // Address is the pre-increment count, so N == 2^ADDR_W ends at the top address.
                  r_xor     <= r_xor ^ i_in_data;
                  r_wr_en   <= 1'b1;
                  r_wr_data <= INSTR_W'({r_ins_hi, i_in_data});
                  r_wr_addr <= r_count[ADDR_W-1:0];
                  r_count   <= r_count + 1'b1;
                  r_remain  <= r_remain - 1'b1;
                  r_state   <= (r_remain == 13'd1) ? StChk : StInsHi;
               end
            end
            StChk: begin
               if (w_xfer) begin
                  if (i_in_data == r_xor) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= StErr;
                     r_error <= 1'b1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_in_ready = w_active;
   assign o_busy     = w_active;
   assign o_wr_en    = r_wr_en;
   assign o_wr_addr  = r_wr_addr;
   assign o_wr_data  = r_wr_data;
   assign o_done     = r_done;
   assign o_error    = r_error;
   assign o_count    = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed frames queue expected writes and end status,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_imem_loader;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic        i_in_valid;
   logic [7:0]  i_in_data;
   logic        o_in_ready;
   logic        o_wr_en;
   logic [11:0] o_wr_addr;
   logic [8:0]  o_wr_data;
   logic        o_busy;
   logic        o_done;
   logic        o_error;
   logic [12:0] o_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [20:0] wr_q[$];   // {addr, data}
   logic [14:0] st_q[$];   // {done, error, count}
   logic        prev_busy = 1'b0;

   imem_loader #(.ADDR_W(12), .INSTR_W(9)) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_start    (i_start),
      .i_in_valid (i_in_valid),
      .i_in_data  (i_in_data),
      .o_in_ready (o_in_ready),
      .o_wr_en    (o_wr_en),
      .o_wr_addr  (o_wr_addr),
      .o_wr_data  (o_wr_data),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_error    (o_error),
      .o_count    (o_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares every write strobe and the end status whenever busy falls.
   always @(negedge i_clk) begin
      if (i_reset) begin
         prev_busy = 1'b0;
      end else begin
         if (o_wr_en) begin
            if (wr_q.size() == 0) begin
               check("unexpected_write", {11'd0, o_wr_addr, o_wr_data}, 32'hFFFF_FFFF);
            end else begin
               check("write", {11'd0, o_wr_addr, o_wr_data}, {11'd0, wr_q.pop_front()});
            end
         end
         if (prev_busy && !o_busy) begin
            if (st_q.size() == 0) begin
               check("unexpected_status", {17'd0, o_done, o_error, o_count}, 32'hFFFF_FFFF);
            end else begin
               check("status", {17'd0, o_done, o_error, o_count}, {17'd0, st_q.pop_front()});
            end
         end
         prev_busy = o_busy;
      end
   end

   task automatic pulse_start();
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      i_in_valid = 1'b1;
      i_in_data  = b;
      while (!o_in_ready && n < 20) begin
         @(posedge i_clk); #1;
         n++;
      end
      if (!o_in_ready) check("ready_timeout", 32'd0, 32'd1);
      @(posedge i_clk); #1;
      i_in_valid = 1'b0;
   endtask

   task automatic push_frame1_writes();
      wr_q.push_back({12'd0, 9'h123});
      wr_q.push_back({12'd1, 9'h045});
   endtask

   initial begin
      logic [7:0]  chk;
      logic [12:0] v;

      i_reset = 1'b1; i_start = 1'b0; i_in_valid = 1'b0; i_in_data = 8'h00;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset_ready", {31'd0, o_in_ready}, 32'd0);
      check("reset_busy",  {31'd0, o_busy}, 32'd0);
      check("reset_flags", {30'd0, o_done, o_error}, 32'd0);
      check("reset_count", {19'd0, o_count}, 32'd0);
      i_reset = 1'b0;
      @(posedge i_clk); #1;

      // 1: two-instruction frame, good checksum
      pulse_start();
      check("start_busy", {31'd0, o_busy}, 32'd1);
      push_frame1_writes();
      st_q.push_back({1'b1, 1'b0, 13'd2});
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h01); send_byte(8'h23);
      send_byte(8'h00); send_byte(8'h45); send_byte(8'h65);
      check("s1_done", {30'd0, o_done, o_error}, 32'd2);
      check("s1_ready_after_chk", {31'd0, o_in_ready}, 32'd0);
      repeat (2) @(posedge i_clk);
      #1;

      // 2: bad checksum, writes still happen
      pulse_start();
      push_frame1_writes();
      st_q.push_back({1'b0, 1'b1, 13'd2});
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h01); send_byte(8'h23);
      send_byte(8'h00); send_byte(8'h45); send_byte(8'h66);
      check("s2_error", {30'd0, o_done, o_error}, 32'd1);
      repeat (2) @(posedge i_clk);
      #1;
      pulse_start();
      check("s2_restart_busy", {31'd0, o_busy}, 32'd1);
      check("s2_restart_clear", {17'd0, o_done, o_error, o_count}, 32'd0);

      // 3: empty frame (continues from the restart above)
      st_q.push_back({1'b1, 1'b0, 13'd0});
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("s3_done", {30'd0, o_done, o_error}, 32'd2);
      repeat (2) @(posedge i_clk);
      #1;

      // 4: N = 4097 is rejected right after LEN_LO
      pulse_start();
      st_q.push_back({1'b0, 1'b1, 13'd0});
      send_byte(8'h10); send_byte(8'h01);
      check("s4_error", {30'd0, o_done, o_error}, 32'd1);
      check("s4_ready", {31'd0, o_in_ready}, 32'd0);
      repeat (2) @(posedge i_clk);
      #1;

      // 5a: reserved bits set in INS_HI
      pulse_start();
      st_q.push_back({1'b0, 1'b1, 13'd0});
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h03);
      check("s5a_error", {30'd0, o_done, o_error}, 32'd1);
      repeat (2) @(posedge i_clk);
      #1;

      // 5b: in_valid low for 5 cycles mid-frame
      pulse_start();
      push_frame1_writes();
      st_q.push_back({1'b1, 1'b0, 13'd0 + 13'd2});
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h01);
      for (int i = 0; i < 5; i++) begin
         @(posedge i_clk); #1;
         check("s5b_hold", {28'd0, o_in_ready, o_busy, o_wr_en, o_done}, 32'hC);
      end
      send_byte(8'h23); send_byte(8'h00); send_byte(8'h45); send_byte(8'h65);
      check("s5b_done", {17'd0, o_done, o_error, o_count}, {17'd0, 2'b10, 13'd2});
      repeat (2) @(posedge i_clk);
      #1;

      // 6: async reset after the first write, then a clean reload
      pulse_start();
      wr_q.push_back({12'd0, 9'h123});
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h01); send_byte(8'h23);
      @(negedge i_clk);
      #2;
      i_reset = 1'b1;
      #1;
      check("s6_async_reset",
            {7'd0, o_in_ready, o_wr_en, o_busy, o_done, o_error, o_count[7:0], o_wr_data, 3'd0},
            32'd0);
      check("s6_async_addr", {7'd0, o_wr_addr, o_count}, 32'd0);
      @(negedge i_clk);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      @(posedge i_clk); #1;
      pulse_start();
      push_frame1_writes();
      st_q.push_back({1'b1, 1'b0, 13'd2});
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h01); send_byte(8'h23);
      send_byte(8'h00); send_byte(8'h45); send_byte(8'h65);
      repeat (2) @(posedge i_clk);
      #1;

      // Boundary: N = 4096 fills the whole memory with no wrap
      pulse_start();
      chk = 8'h10;
      send_byte(8'h10); send_byte(8'h00);
      for (int i = 0; i < 4096; i++) begin
         v = 13'(i);
         wr_q.push_back({v[11:0], v[8:0]});
         chk = chk ^ {7'd0, v[8]} ^ v[7:0];
         send_byte({7'd0, v[8]});
         send_byte(v[7:0]);
      end
      st_q.push_back({1'b1, 1'b0, 13'd4096});
      send_byte(chk);
      check("full_last_addr", {20'd0, o_wr_addr}, 32'hFFF);
      repeat (2) @(posedge i_clk);
      #1;

      // reset wins over a simultaneous start
      i_reset = 1'b1; i_start = 1'b1;
      @(posedge i_clk); #1;
      check("reset_beats_start", {31'd0, o_busy}, 32'd0);
      i_start = 1'b0;
      @(negedge i_clk);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;

      check("writes_drained", wr_q.size(), 32'd0);
      check("status_drained", st_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
